// File: rtl/base_integer_pipe_ctrl_unit_pkg.sv
// ============================================================================
// base_integer_pipe_ctrl_unit_pkg
// RV32I opcodes, control-bundle bit positions and field codes.
// Rev 1.0
// ============================================================================
`default_nettype none

package base_integer_pipe_ctrl_unit_pkg;

  localparam logic [6:0] c_opc_r      = 7'b0110011;
  localparam logic [6:0] c_opc_i      = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;

  localparam int c_b_reg_write  = 0;
  localparam int c_b_mem_read   = 1;
  localparam int c_b_mem_write  = 2;
  localparam int c_b_alu_src    = 3;
  localparam int c_b_mem_to_reg = 4;
  localparam int c_b_alu_op     = 5;
  localparam int c_b_dsize      = 7;
  localparam int c_b_branch     = 9;
  localparam int c_b_jal        = 10;
  localparam int c_b_jalr       = 11;
  localparam int c_b_unsigned   = 12;

  localparam logic [1:0] c_aluop_add    = 2'b00;
  localparam logic [1:0] c_aluop_branch = 2'b01;
  localparam logic [1:0] c_aluop_imm    = 2'b10;
  localparam logic [1:0] c_aluop_reg    = 2'b11;

  localparam logic [1:0] c_dsize_none = 2'b00;
  localparam logic [1:0] c_dsize_byte = 2'b01;
  localparam logic [1:0] c_dsize_half = 2'b10;
  localparam logic [1:0] c_dsize_word = 2'b11;

  // Memory access width from func3[1:0]; the reserved 11 encoding maps to none.
  function automatic logic [1:0] dsize_from_f3(input logic [1:0] f3);
    logic [1:0] w_size;
    case (f3)
      2'b00:   w_size = c_dsize_byte;
      2'b01:   w_size = c_dsize_half;
      2'b10:   w_size = c_dsize_word;
      default: w_size = c_dsize_none;
    endcase
    return w_size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/base_integer_pipe_ctrl_unit_if.sv
// ============================================================================
// base_integer_pipe_ctrl_unit_if
// IF/ID decode inputs and ID/EX control outputs of the control unit.
// Rev 1.0
// ============================================================================
`default_nettype none

interface base_integer_pipe_ctrl_unit_if #(
  parameter int NB_CTRL = 13,
  parameter int NB_REG  = 5,
  parameter int NB_CNT  = 32
);
  logic               i_en;
  logic               i_valid;
  logic [6:0]         i_opcode;
  logic [2:0]         i_func3;
  logic [NB_REG-1:0]  i_rs1;
  logic [NB_REG-1:0]  i_rs2;
  logic [NB_REG-1:0]  i_rd;
  logic               i_flush;
  logic [NB_CTRL-1:0] o_ctrl;
  logic               o_valid;
  logic [NB_REG-1:0]  o_rd;
  logic               o_illegal;
  logic               o_stall;
  logic [NB_CNT-1:0]  o_stall_cnt;
  logic [NB_CNT-1:0]  o_flush_cnt;

  modport master (
    output i_en, i_valid, i_opcode, i_func3, i_rs1, i_rs2, i_rd, i_flush,
    input  o_ctrl, o_valid, o_rd, o_illegal, o_stall, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_en, i_valid, i_opcode, i_func3, i_rs1, i_rs2, i_rd, i_flush,
    output o_ctrl, o_valid, o_rd, o_illegal, o_stall, o_stall_cnt, o_flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/base_integer_pipe_ctrl_unit_decoder.sv
// ============================================================================
// base_integer_decoder
// Combinational opcode/func3 decode into the control bundle plus operand use.
// Rev 1.0
// ============================================================================
`default_nettype none

module base_integer_decoder
  import base_integer_pipe_ctrl_unit_pkg::*;
#(
  parameter int NB_CTRL = 13,
  parameter int NB_REG  = 5
) (
  input  wire logic [6:0]         i_opcode,
  input  wire logic [2:0]         i_func3,
  input  wire logic [NB_REG-1:0]  i_rd,
  output logic      [NB_CTRL-1:0] o_ctrl,
  output logic                    o_use1,
  output logic                    o_use2,
  output logic                    o_illegal
);

  always_comb begin
    o_ctrl    = '0;
    o_use1    = 1'b0;
    o_use2    = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      c_opc_r: begin
        o_ctrl[c_b_reg_write]     = 1'b1;
        o_ctrl[c_b_alu_op +: 2]   = c_aluop_reg;
        o_use1                    = 1'b1;
        o_use2                    = 1'b1;
      end
      c_opc_i: begin
        o_ctrl[c_b_reg_write]     = 1'b1;
        o_ctrl[c_b_alu_src]       = 1'b1;
        o_ctrl[c_b_alu_op +: 2]   = c_aluop_imm;
        o_use1                    = 1'b1;
      end
      c_opc_load: begin
        o_ctrl[c_b_reg_write]     = 1'b1;
        o_ctrl[c_b_mem_read]      = 1'b1;
        o_ctrl[c_b_alu_src]       = 1'b1;
        o_ctrl[c_b_mem_to_reg]    = 1'b1;
        o_ctrl[c_b_alu_op +: 2]   = c_aluop_add;
        o_ctrl[c_b_dsize +: 2]    = dsize_from_f3(i_func3[1:0]);
        o_ctrl[c_b_unsigned]      = i_func3[2];
        o_use1                    = 1'b1;
      end
      c_opc_store: begin
        o_ctrl[c_b_mem_write]     = 1'b1;
        o_ctrl[c_b_alu_src]       = 1'b1;
        o_ctrl[c_b_dsize +: 2]    = dsize_from_f3(i_func3[1:0]);
        o_use1                    = 1'b1;
        o_use2                    = 1'b1;
      end
      c_opc_lui, c_opc_auipc: begin
        o_ctrl[c_b_reg_write]     = 1'b1;
        o_ctrl[c_b_alu_src]       = 1'b1;
      end
      c_opc_branch: begin
        o_ctrl[c_b_branch]        = 1'b1;
        o_ctrl[c_b_alu_op +: 2]   = c_aluop_branch;
        o_use1                    = 1'b1;
        o_use2                    = 1'b1;
      end
      c_opc_jal: begin
        o_ctrl[c_b_reg_write]     = 1'b1;
        o_ctrl[c_b_jal]           = 1'b1;
      end
      c_opc_jalr: begin
        o_ctrl[c_b_reg_write]     = 1'b1;
        o_ctrl[c_b_alu_src]       = 1'b1;
        o_ctrl[c_b_jalr]          = 1'b1;
        o_use1                    = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
    // x0 is hardwired, so never let anything claim a write to it.
    if (i_rd == '0) o_ctrl[c_b_reg_write] = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/base_integer_pipe_ctrl_unit.sv
// ============================================================================
// base_integer_pipe_ctrl_unit
// ID-stage control: decode, ID/EX register, load-use stall, flush squash.
// Optional perf counters enabled by defining CTRL_PERF_CNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module base_integer_pipe_ctrl_unit
  import base_integer_pipe_ctrl_unit_pkg::*;
#(
  parameter int NB_CTRL = 13,
  parameter int NB_REG  = 5,
  parameter int NB_CNT  = 32
) (
  input  wire logic                    i_clk,
  input  wire logic                    i_rst,
  base_integer_pipe_ctrl_unit_if.slave bus
);

  logic [NB_CTRL-1:0] w_dec_ctrl;
  logic               w_use1;
  logic               w_use2;
  logic               w_dec_illegal;
  logic               w_stall;

  logic [NB_CTRL-1:0] r_ctrl;
  logic               r_valid;
  logic [NB_REG-1:0]  r_rd;
  logic               r_illegal;

  base_integer_decoder #(
    .NB_CTRL (NB_CTRL),
    .NB_REG  (NB_REG)
  ) u_decoder (
    .i_opcode  (bus.i_opcode),
    .i_func3   (bus.i_func3),
    .i_rd      (bus.i_rd),
    .o_ctrl    (w_dec_ctrl),
    .o_use1    (w_use1),
    .o_use2    (w_use2),
    .o_illegal (w_dec_illegal)
  );

  // A load in EX whose result the ID instruction needs cannot be forwarded yet.
  assign w_stall = bus.i_valid & r_valid & r_ctrl[c_b_mem_read] & (r_rd != '0)
                 & ((w_use1 & (bus.i_rs1 == r_rd)) | (w_use2 & (bus.i_rs2 == r_rd)))
                 & ~bus.i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else if (bus.i_flush || (bus.i_en && w_stall)) begin
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else if (!bus.i_en) begin
      r_illegal <= 1'b0;
    end else begin
      r_ctrl    <= bus.i_valid ? w_dec_ctrl : '0;
      r_valid   <= bus.i_valid;
      r_rd      <= bus.i_rd;
      r_illegal <= bus.i_valid & w_dec_illegal;
    end
  end

  assign bus.o_ctrl    = r_ctrl;
  assign bus.o_valid   = r_valid;
  assign bus.o_rd      = r_rd;
  assign bus.o_illegal = r_illegal;
  assign bus.o_stall   = w_stall;

`ifdef CTRL_PERF_CNT_EN
  localparam logic [NB_CNT-1:0] c_cnt_one = {{(NB_CNT-1){1'b0}}, 1'b1};

  logic [NB_CNT-1:0] r_stall_cnt;
  logic [NB_CNT-1:0] r_flush_cnt;

  // Both counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && bus.i_en && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + c_cnt_one;
      if (bus.i_flush && !(&r_flush_cnt))        r_flush_cnt <= r_flush_cnt + c_cnt_one;
    end
  end

  assign bus.o_stall_cnt = r_stall_cnt;
  assign bus.o_flush_cnt = r_flush_cnt;
`else
  assign bus.o_stall_cnt = '0;
  assign bus.o_flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_base_integer_pipe_ctrl_unit.sv
// ============================================================================
// tb_base_integer_pipe_ctrl_unit
// Directed vector table, counter corner sequences and a random run.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_base_integer_pipe_ctrl_unit;

  localparam int NB_CNT = 4;
`ifdef CTRL_PERF_CNT_EN
  localparam bit c_perf = 1'b1;
`else
  localparam bit c_perf = 1'b0;
`endif

  typedef struct {
    logic        rst, en, valid;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic        flush;
    logic [12:0] e_ctrl;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic        e_ill;
    logic        e_stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  base_integer_pipe_ctrl_unit_if #(.NB_CTRL(13), .NB_REG(5), .NB_CNT(NB_CNT)) bus ();

  base_integer_pipe_ctrl_unit #(.NB_CTRL(13), .NB_REG(5), .NB_CNT(NB_CNT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: what sits in the ID/EX slot and the event tallies.
  logic [12:0]       m_ctrl;
  logic              m_valid;
  logic [4:0]        m_rd;
  logic              m_ill;
  int                m_sc, m_fc;
  logic              m_stall;

  function automatic bit known(input logic [6:0] o);
    return o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
                     7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111};
  endfunction

  function automatic bit reads1(input logic [6:0] o);
    return o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
  endfunction

  function automatic bit reads2(input logic [6:0] o);
    return o inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic logic [12:0] ref_ctrl(input logic [6:0] o, input logic [2:0] f3,
                                           input logic [4:0] rd);
    int c = 0;
    int sz = (int'(f3[1:0]) + 1) % 4;
    case (o)
      7'b0110011:             c = 'h061;
      7'b0010011:             c = 'h049;
      7'b0000011:             c = 'h01B + sz * 128 + int'(f3[2]) * 4096;
      7'b0100011:             c = 'h00C + sz * 128;
      7'b0110111, 7'b0010111: c = 'h009;
      7'b1100011:             c = 'h220;
      7'b1101111:             c = 'h401;
      7'b1100111:             c = 'h809;
      default:                c = 0;
    endcase
    if (rd == 5'd0 && c % 2 == 1) c = c - 1;
    return 13'(c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, e, v, input logic [6:0] o, input logic [2:0] f,
                              input logic [4:0] s1, s2, d, input logic fl,
                              input logic [12:0] ec, input logic ev, input logic [4:0] ed,
                              input logic ei, es);
    vec_t t;
    t.rst = r; t.en = e; t.valid = v; t.opc = o; t.f3 = f;
    t.rs1 = s1; t.rs2 = s2; t.rd = d; t.flush = fl;
    t.e_ctrl = ec; t.e_valid = ev; t.e_rd = ed; t.e_ill = ei; t.e_stall = es;
    return t;
  endfunction

  // One clock: drive, check the combinational stall, advance, check outputs.
  task automatic run_cycle(input vec_t v, input bit use_tbl);
    int sat = (1 << NB_CNT) - 1;
    rst = v.rst;
    bus.i_en = v.en; bus.i_valid = v.valid; bus.i_opcode = v.opc; bus.i_func3 = v.f3;
    bus.i_rs1 = v.rs1; bus.i_rs2 = v.rs2; bus.i_rd = v.rd; bus.i_flush = v.flush;
    #4;
    m_stall = v.valid && m_valid && m_ctrl[1] && m_rd != 0 && !v.flush &&
              ((reads1(v.opc) && v.rs1 == m_rd) || (reads2(v.opc) && v.rs2 == m_rd));
    chk("stall", bus.o_stall, use_tbl ? v.e_stall : m_stall);
    if (v.rst) begin
      m_ctrl = 0; m_valid = 0; m_rd = 0; m_ill = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (v.flush && m_fc < sat) m_fc++;
      if (m_stall && v.en && m_sc < sat) m_sc++;
      if (v.flush || (v.en && m_stall)) begin
        m_ctrl = 0; m_valid = 0; m_rd = 0; m_ill = 0;
      end else if (!v.en) begin
        m_ill = 0;
      end else begin
        m_ctrl  = v.valid ? ref_ctrl(v.opc, v.f3, v.rd) : 13'd0;
        m_valid = v.valid;
        m_rd    = v.rd;
        m_ill   = v.valid && !known(v.opc);
      end
    end
    @(posedge clk);
    #1;
    chk("ctrl",    bus.o_ctrl,    use_tbl ? v.e_ctrl  : m_ctrl);
    chk("valid",   bus.o_valid,   use_tbl ? v.e_valid : m_valid);
    chk("rd",      bus.o_rd,      use_tbl ? v.e_rd    : m_rd);
    chk("illegal", bus.o_illegal, use_tbl ? v.e_ill   : m_ill);
    chk("stall_cnt", bus.o_stall_cnt, c_perf ? m_sc : 0);
    chk("flush_cnt", bus.o_flush_cnt, c_perf ? m_fc : 0);
  endtask

  vec_t tbl[25];
  vec_t v;

  initial begin
    tbl[0]  = mk(1,0,0, 7'h00,3'd0, 0,0,0, 0, 13'h000,0,0,0,0);
    tbl[1]  = mk(1,0,0, 7'h00,3'd0, 0,0,0, 0, 13'h000,0,0,0,0);
    tbl[2]  = mk(0,1,1, 7'h33,3'd0, 1,2,3, 0, 13'h061,1,3,0,0);   // ADD x3,x1,x2
    tbl[3]  = mk(0,0,1, 7'h13,3'd0, 0,0,4, 0, 13'h061,1,3,0,0);   // held
    tbl[4]  = mk(0,0,1, 7'h13,3'd0, 0,0,4, 0, 13'h061,1,3,0,0);
    tbl[5]  = mk(0,0,1, 7'h13,3'd0, 0,0,4, 0, 13'h061,1,3,0,0);
    tbl[6]  = mk(0,1,1, 7'h03,3'd4, 1,0,5, 0, 13'h109B,1,5,0,0);  // LBU x5
    tbl[7]  = mk(0,1,1, 7'h03,3'd2, 1,0,5, 0, 13'h19B,1,5,0,0);   // LW x5
    tbl[8]  = mk(0,1,1, 7'h33,3'd0, 5,1,6, 0, 13'h000,0,0,0,1);   // ADD x6,x5,x1 stalls
    tbl[9]  = mk(0,1,1, 7'h33,3'd0, 5,1,6, 0, 13'h061,1,6,0,0);
    tbl[10] = mk(0,1,1, 7'h03,3'd2, 2,0,7, 0, 13'h19B,1,7,0,0);
    tbl[11] = mk(0,1,1, 7'h33,3'd0, 1,7,8, 1, 13'h000,0,0,0,0);   // hazard + flush
    tbl[12] = mk(0,1,1, 7'h03,3'd2, 2,0,7, 0, 13'h19B,1,7,0,0);
    tbl[13] = mk(0,0,1, 7'h33,3'd0, 7,1,8, 1, 13'h000,0,0,0,0);   // flush with en=0
    tbl[14] = mk(0,1,1, 7'h13,3'd0, 1,0,0, 0, 13'h048,1,0,0,0);   // ADDI x0
    tbl[15] = mk(0,1,1, 7'h7F,3'd0, 1,2,9, 0, 13'h000,1,9,1,0);   // illegal
    tbl[16] = mk(0,1,1, 7'h33,3'd0, 1,2,3, 0, 13'h061,1,3,0,0);
    tbl[17] = mk(0,1,1, 7'h63,3'd0, 3,4,0, 0, 13'h220,1,0,0,0);   // BEQ
    tbl[18] = mk(0,1,1, 7'h6F,3'd0, 0,0,1, 0, 13'h401,1,1,0,0);   // JAL
    tbl[19] = mk(0,1,1, 7'h67,3'd0, 2,0,1, 0, 13'h809,1,1,0,0);   // JALR
    tbl[20] = mk(0,1,1, 7'h23,3'd1, 1,2,0, 0, 13'h10C,1,0,0,0);   // SH
    tbl[21] = mk(0,1,1, 7'h37,3'd0, 0,0,2, 0, 13'h009,1,2,0,0);   // LUI
    tbl[22] = mk(0,1,0, 7'h33,3'd0, 1,2,3, 0, 13'h000,0,3,0,0);   // no instruction
    tbl[23] = mk(0,1,1, 7'h03,3'd5, 1,0,4, 0, 13'h111B,1,4,0,0);  // LHU x4
    tbl[24] = mk(1,1,1, 7'h33,3'd0, 4,1,5, 0, 13'h000,0,0,0,1);   // reset mid-stall

    m_ctrl = 0; m_valid = 0; m_rd = 0; m_ill = 0; m_sc = 0; m_fc = 0;
    rst = 1'b1;
    bus.i_en = 0; bus.i_valid = 0; bus.i_opcode = 0; bus.i_func3 = 0;
    bus.i_rs1 = 0; bus.i_rs2 = 0; bus.i_rd = 0; bus.i_flush = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) run_cycle(tbl[i], 1'b1);

    // Load-use stall counted once, then flush counting up to saturation.
    run_cycle(mk(0,1,1, 7'h03,3'd2, 1,0,5, 0, 0,0,0,0,0), 1'b0);
    run_cycle(mk(0,1,1, 7'h33,3'd0, 5,1,6, 0, 0,0,0,0,0), 1'b0);
    run_cycle(mk(0,1,1, 7'h33,3'd0, 5,1,6, 0, 0,0,0,0,0), 1'b0);
    chk("stall_cnt_once", bus.o_stall_cnt, c_perf ? 1 : 0);
    run_cycle(mk(0,1,1, 7'h33,3'd0, 5,1,6, 1, 0,0,0,0,0), 1'b0);
    chk("flush_cnt_once", bus.o_flush_cnt, c_perf ? 1 : 0);
    for (int i = 0; i < 20; i++) run_cycle(mk(0,1,1, 7'h13,3'd0, 1,0,2, 1, 0,0,0,0,0), 1'b0);
    chk("flush_cnt_sat", bus.o_flush_cnt, c_perf ? 15 : 0);
    for (int i = 0; i < 20; i++) begin
      run_cycle(mk(0,1,1, 7'h03,3'd2, 1,0,5, 0, 0,0,0,0,0), 1'b0);
      run_cycle(mk(0,1,1, 7'h33,3'd0, 5,1,6, 0, 0,0,0,0,0), 1'b0);
      run_cycle(mk(0,1,1, 7'h33,3'd0, 5,1,6, 0, 0,0,0,0,0), 1'b0);
    end
    chk("stall_cnt_sat", bus.o_stall_cnt, c_perf ? 15 : 0);

    for (int i = 0; i < 600; i++) begin
      logic [6:0] ops [11];
      ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h7F};
      v.rst   = ($urandom_range(0, 99) < 2);
      v.en    = ($urandom_range(0, 99) < 85);
      v.valid = ($urandom_range(0, 99) < 85);
      v.opc   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      v.f3    = 3'($urandom);
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.rd    = 5'($urandom_range(0, 3));
      v.flush = ($urandom_range(0, 99) < 10);
      v.e_ctrl = 0; v.e_valid = 0; v.e_rd = 0; v.e_ill = 0; v.e_stall = 0;
      run_cycle(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
